seq_restoring_divider: RTL and testbench

- Sequential restoring divider, the inverse of the team's 4x4 array multiplier: recovers quotient and remainder from a product and one operand.
- Default configuration divides an 8-bit dividend by a 4-bit divisor, one quotient bit per clock.
- Valid/ready handshake on both the operand side and the result side, so it sits between an input capture stage and an output mux in the tile.

---
 rtl/seq_restoring_divider.sv | 122 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//
// Sequential restoring divider. It produces one quotient bit per clock and
// recovers quotient and remainder from an unsigned dividend/divisor pair.
// Both the operand side and the result side use a valid/ready handshake.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   in_valid     operand pair presented
//   in_ready     block can accept operands (high only in IDLE)
//   dividend     WN-bit unsigned numerator
//   divisor      WD-bit unsigned denominator
//   out_valid    result available (high only in DONE)
//   out_ready    consumer accepts the result
//   quotient     WN-bit floor(dividend / divisor); all ones on divide by zero
//   remainder    WD-bit dividend mod divisor; dividend[WD-1:0] on divide by zero
//   div_by_zero  the divisor of the current result was zero
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int WN = 8,
  parameter int WD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WN-1:0] quotient,
  output logic [WD-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (WN > 1) ? $clog2(WN) : 1;
  localparam logic [CW-1:0] LAST = CW'(WN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [WN-1:0] q;      // dividend shifting out, quotient shifting in
  logic [WD-1:0] d;      // captured divisor
  logic [WD-1:0] r;      // partial remainder
  logic [CW-1:0] count;

  // One restoring step. The partial remainder is always below the divisor,
  // so its top bit is zero and only WD bits are stored. With a zero divisor
  // the remainder just accumulates the low dividend bits, and truncating the
  // difference to WD bits gives the same result as keeping the extra bit.
  logic [WD:0]   t;
  logic          ge;
  logic [WD-1:0] r_next;
  logic [WN-1:0] q_next;

  always_comb begin
    t      = {r, q[WN-1]};
    ge     = (t >= {1'b0, d});
    r_next = ge ? (t[WD-1:0] - d) : t[WD-1:0];
    q_next = {q[WN-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q        <= dividend;
            d        <= divisor;
            r        <= '0;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          q     <= q_next;
          r     <= r_next;
          count <= count + 1'b1;
          // Output registers load from this edge's step, not from q/r.
          if (count == LAST) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= (d == '0) ? '1 : q_next;
            remainder   <= r_next;
            div_by_zero <= (d == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Self-checking bench for seq_restoring_divider (WN=8, WD=4). Inputs are
// driven on the falling edge and outputs are sampled on the falling edge.
// Expected results come from plain integer division in ref_div.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WN(8), .WD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Reference: integer division, with the divide-by-zero convention.
  task automatic ref_div(input int a, input int b,
                         output logic [7:0] eq, output logic [3:0] er,
                         output logic ez);
    if (b == 0) begin
      eq = 8'hFF;
      er = 4'(a % 16);
      ez = 1'b1;
    end else begin
      eq = 8'(a / b);
      er = 4'(a % b);
      ez = 1'b0;
    end
  endtask

  // Presents one operand pair for a single cycle; returns at the falling
  // edge just after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen
  // (bounded at 40).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (quotient !== 8'd0) begin miscompares++; $display("FAIL reset_quotient got %0d want 0", quotient); end
    vectors++; if (remainder !== 4'd0) begin miscompares++; $display("FAIL reset_remainder got %0d want 0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    issue(8'd143, 4'd11);
    wait_valid(n);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL basic_latency got %0d want 8", n); end
    vectors++; if (quotient !== 8'd13) begin miscompares++; $display("FAIL basic_quotient got %0d want 13", quotient); end
    vectors++; if (remainder !== 4'd0) begin miscompares++; $display("FAIL basic_remainder got %0d want 0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_handoff_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_handoff_in_ready got %b want 1", in_ready); end
    vectors++; if (quotient !== 8'd13) begin miscompares++; $display("FAIL basic_hold_quotient got %0d want 13", quotient); end
  endtask

  task automatic test_back_to_back;
    int a_tab[3] = '{255, 200, 5};
    int b_tab[3] = '{15, 7, 9};
    int acc[3];
    int cyc = 0;
    int n;
    bit busy_ready;
    logic [7:0] eq; logic [3:0] er; logic ez;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready_at_accept op %0d got %b want 1", i, in_ready); end
      dividend = 8'(a_tab[i]);
      divisor  = 4'(b_tab[i]);
      in_valid = 1'b1;
      acc[i] = cyc;
      @(negedge clk); cyc++;
      n = 0;
      busy_ready = 1'b0;
      while (!out_valid && n < 40) begin
        if (in_ready) busy_ready = 1'b1;
        @(negedge clk); cyc++; n++;
      end
      if (in_ready) busy_ready = 1'b1;
      ref_div(a_tab[i], b_tab[i], eq, er, ez);
      vectors++; if (busy_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready_busy op %0d got 1 want 0", i); end
      vectors++; if (quotient !== eq) begin miscompares++; $display("FAIL b2b_quotient op %0d got %0d want %0d", i, quotient, eq); end
      vectors++; if (remainder !== er) begin miscompares++; $display("FAIL b2b_remainder op %0d got %0d want %0d", i, remainder, er); end
      if (i > 0) begin
        vectors++; if (acc[i] - acc[i-1] !== 10) begin miscompares++; $display("FAIL b2b_spacing op %0d got %0d want 10", i, acc[i] - acc[i-1]); end
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    issue(8'd200, 4'd7);
    wait_valid(n);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL bp_latency got %0d want 8", n); end
    for (int k = 0; k < 6; k++) begin
      vectors++; if (quotient !== 8'd28 || remainder !== 4'd4 || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin miscompares++; $display("FAIL bp_hold cycle %0d got q=%0d r=%0d ov=%b ir=%b want q=28 r=4 ov=1 ir=0", k, quotient, remainder, out_valid, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_div_zero;
    int n;
    out_ready = 1'b1;
    issue(8'd77, 4'd0);
    wait_valid(n);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL dz_latency got %0d want 8", n); end
    vectors++; if (quotient !== 8'd255) begin miscompares++; $display("FAIL dz_quotient got %0d want 255", quotient); end
    vectors++; if (remainder !== 4'd13) begin miscompares++; $display("FAIL dz_remainder got %0d want 13", remainder); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    issue(8'd77, 4'd3);
    wait_valid(n);
    vectors++; if (quotient !== 8'd25 || remainder !== 4'd2) begin miscompares++; $display("FAIL dz_follow got q=%0d r=%0d want q=25 r=2", quotient, remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dz_follow_flag got %b want 0", div_by_zero); end
  endtask

  task automatic test_async_reset;
    int n;
    out_ready = 1'b1;
    issue(8'd100, 4'd3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ctrl got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    vectors++; if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0)
      begin miscompares++; $display("FAIL arst_outputs got q=%0d r=%0d z=%b want 0 0 0", quotient, remainder, div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
    issue(8'd100, 4'd3);
    wait_valid(n);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL arst_latency got %0d want 8", n); end
    vectors++; if (quotient !== 8'd33 || remainder !== 4'd1) begin miscompares++; $display("FAIL arst_result got q=%0d r=%0d want q=33 r=1", quotient, remainder); end
  endtask

  task automatic test_ignore_inputs;
    int n;
    bit extra;
    out_ready = 1'b1;
    issue(8'd143, 4'd11);
    for (int k = 0; k < 4; k++) begin
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      in_valid = k[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_valid(n);
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL ign_latency got %0d more edges want 4", n); end
    vectors++; if (quotient !== 8'd13 || remainder !== 4'd0) begin miscompares++; $display("FAIL ign_result got q=%0d r=%0d want q=13 r=0", quotient, remainder); end
    extra = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) extra = 1'b1;
    end
    vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL ign_no_extra_op got busy want idle"); end
  endtask

  task automatic test_random;
    int a, b, n, stall;
    logic [7:0] eq; logic [3:0] er; logic ez;
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      stall = int'($urandom_range(0, 3));
      out_ready = (stall == 0);
      issue(8'(a), 4'(b));
      wait_valid(n);
      ref_div(a, b, eq, er, ez);
      vectors++; if (n !== 8 || quotient !== eq || remainder !== er || div_by_zero !== ez)
        begin miscompares++; $display("FAIL rand %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=8 q=%0d r=%0d z=%b", a, b, n, quotient, remainder, div_by_zero, eq, er, ez); end
      repeat (stall) @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || quotient !== eq) begin miscompares++; $display("FAIL rand_stall_hold got ov=%b q=%0d want ov=1 q=%0d", out_valid, quotient, eq); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_div_zero();
    test_async_reset();
    test_ignore_inputs();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
